seg_ripple_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operation in SEG-bit ripple segments, one segment per clock, with the carry held in a register between cycles. It lets wide arithmetic share a short combinational carry chain, trading latency for timing. Operands enter and results leave through valid/ready handshakes, so the block sits between any producer and consumer in the datapath.

---
 rtl/seg_ripple_adder.sv | 133 +++++++++++++
 tb/tb_seg_ripple_adder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_ripple_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operation rippled SEG bits per clock, carry held between cycles.
// Optional zero/ovf flag logic enabled by defining SEG_RIPPLE_ADDER_FLAGS_EN.
module seg_ripple_adder #(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             zero,
   output logic             ovf
);
   localparam int NSEG = WIDTH / SEG;
   localparam int KW   = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NSEG - 1);

   generate
      if (WIDTH % SEG != 0) begin : g_bad_seg
         $error("seg_ripple_adder: WIDTH must be a multiple of SEG");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_a, r_b, r_work, w_work_nxt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_carry;
   logic [KW-1:0]    r_k;
   logic [SEG-1:0]   w_seg_a, w_seg_b, w_seg_s;
   logic             w_seg_c;
   logic             w_accept, w_last, w_busy;

   assign w_accept = (r_state == IDLE) && in_valid;
   assign w_busy   = (r_state == BUSY);
   assign w_last   = (r_k == K_LAST);

   // The one SEG-bit ripple chain shared by every segment
   assign w_seg_a = r_a[int'(r_k)*SEG +: SEG];
   assign w_seg_b = r_b[int'(r_k)*SEG +: SEG];
   assign {w_seg_c, w_seg_s} = {1'b0, w_seg_a} + {1'b0, w_seg_b} + {{SEG{1'b0}}, r_carry};

   always_comb begin
      w_work_nxt = r_work;
      w_work_nxt[int'(r_k)*SEG +: SEG] = w_seg_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_nxt = BUSY;
         BUSY:    if (w_last)    w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default:                w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_work  <= '0;
         r_carry <= 1'b0;
         r_k     <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else if (w_accept) begin
         // Subtract as a + ~b + ~borrow
         r_a     <= a;
         r_b     <= b ^ {WIDTH{sub}};
         r_carry <= cin ^ sub;
         r_k     <= '0;
      end else if (w_busy) begin
         r_work  <= w_work_nxt;
         r_carry <= w_seg_c;
         if (w_last) begin
            r_k    <= '0;
            r_sum  <= w_work_nxt;
            r_cout <= w_seg_c;
         end else begin
            r_k <= r_k + KW'(1);
         end
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;

`ifdef SEG_RIPPLE_ADDER_FLAGS_EN
   logic w_msb_cin;
   logic r_zero, r_ovf;

   // Carry into the MSB recovered from the MSB's own sum bit
   assign w_msb_cin = w_seg_a[SEG-1] ^ w_seg_b[SEG-1] ^ w_seg_s[SEG-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_zero <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (w_busy && w_last) begin
         r_zero <= ~|w_work_nxt;
         r_ovf  <= w_msb_cin ^ w_seg_c;
      end
   end

   assign zero = r_zero;
   assign ovf  = r_ovf;
`else
   assign zero = 1'b0;
   assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_seg_ripple_adder.sv
// Bench for seg_ripple_adder: 32/8 instance (vector table + scoreboard) and 8/8 instance (single-segment).
module tb_seg_ripple_adder;
   localparam int W  = 32;
   localparam int S  = 8;
   localparam int NS = W / S;
`ifdef SEG_RIPPLE_ADDER_FLAGS_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout, zero, ovf;
   logic [W-1:0]  a, b, sum;
   logic          in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, zero8, ovf8;
   logic [7:0]    a8, b8, sum8;

   typedef struct {
      logic [31:0] a, b;
      logic        cin, sub;
      logic [31:0] sum;
      logic        cout, zero, ovf;
   } vec_t;

   typedef struct {
      logic [31:0] sum;
      logic        cout, zero, ovf;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   seg_ripple_adder #(.WIDTH(W), .SEG(S)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .zero(zero), .ovf(ovf)
   );

   seg_ripple_adder #(.WIDTH(8), .SEG(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
      .sum(sum8), .cout(cout8), .zero(zero8), .ovf(ovf8)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib, input logic icin, input logic isub);
      exp_t        e;
      logic [31:0] bb;
      logic [32:0] r;
      bb     = ib ^ {32{isub}};
      r      = {1'b0, ia} + {1'b0, bb} + {32'd0, icin ^ isub};
      e.sum  = r[31:0];
      e.cout = r[32];
      e.zero = FL && (r[31:0] == 32'd0);
      e.ovf  = FL && (ia[31] == bb[31]) && (r[31] != ia[31]);
      return e;
   endfunction

   task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic icin,
                         input logic isub, input exp_t e, input string nm);
      int   cyc;
      exp_t got;
      @(negedge clk);
      a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1;
      cyc = 0;
      while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
      chk($sformatf("%s_in_ready", nm), in_ready, 1);
      @(posedge clk);
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      cyc = 0;
      while (!out_valid && cyc < 50) begin @(negedge clk); cyc++; end
      chk($sformatf("%s_latency", nm), cyc, NS);
      chk($sformatf("%s_sb_depth", nm), sb.size(), 1);
      if (sb.size() > 0) got = sb.pop_front();
      else               got = '{default: '0};
      chk($sformatf("%s_sum", nm), sum, got.sum);
      chk($sformatf("%s_cout", nm), cout, got.cout);
      chk($sformatf("%s_zero", nm), zero, got.zero);
      chk($sformatf("%s_ovf", nm), ovf, got.ovf);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("%s_post_ov", nm), out_valid, 0);
      chk($sformatf("%s_post_ir", nm), in_ready, 1);
   endtask

   initial begin
      vec_t tbl[8];
      exp_t e;
      int   cyc;
      tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0};
      tbl[1] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1};
      tbl[6] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0};
      tbl[7] = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0, 1'b0};

      in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0; sub = 0;
      in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;

      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_flags", {cout, zero, ovf}, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         e.sum  = tbl[i].sum;
         e.cout = tbl[i].cout;
         e.zero = FL & tbl[i].zero;
         e.ovf  = FL & tbl[i].ovf;
         run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, e, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 6; i++) begin
         logic [31:0] ra, rb;
         logic        rc, rs;
         ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
         run_op(ra, rb, rc, rs, model(ra, rb, rc, rs), $sformatf("rnd%0d", i));
      end

      // Backpressure: result held while new operands are offered
      @(negedge clk);
      a = 32'hFFFFFFF0; b = 32'h00000040; cin = 0; sub = 0; in_valid = 1'b1;
      @(posedge clk);
      sb.push_back(model(32'hFFFFFFF0, 32'h00000040, 1'b0, 1'b0));
      @(negedge clk);
      a = 32'hDEADBEEF; b = 32'h01234567;
      cyc = 0;
      while (!out_valid && cyc < 50) begin
         chk("bp_busy_ir", in_ready, 0);
         @(negedge clk); cyc++;
      end
      chk("bp_latency", cyc, NS);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("bp_ov%0d", i), out_valid, 1);
         chk($sformatf("bp_ir%0d", i), in_ready, 0);
         chk($sformatf("bp_sum%0d", i), sum, 32'h00000030);
         @(negedge clk);
      end
      e = (sb.size() > 0) ? sb.pop_front() : '{default: '0};
      chk("bp_cout", cout, e.cout);
      chk("bp_sum_sb", sum, e.sum);
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_release_ir", in_ready, 1);
      chk("bp_release_ov", out_valid, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("bp_noacc%0d", i), out_valid, 0);
      end

      // Reset while the third segment is in flight
      @(negedge clk);
      a = 32'h01010101; b = 32'h02020202; cin = 0; sub = 0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ov", out_valid, 0);
      chk("mid_rst_ir", in_ready, 1);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_flags", {cout, zero, ovf}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("mid_rst_quiet%0d", i), out_valid, 0);
      end

      // Single-segment instance: 1-cycle latency, issue every 3 cycles
      @(negedge clk);
      a8 = 8'h80; b8 = 8'h7F; cin8 = 1'b1; sub8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b1;
      for (int c = 0; c < 12; c++) begin
         chk($sformatf("w8_ir%0d", c), in_ready8, (c % 3) == 0);
         chk($sformatf("w8_ov%0d", c), out_valid8, (c % 3) == 2);
         if ((c % 3) == 2) begin
            chk($sformatf("w8_sum%0d", c), sum8, 0);
            chk($sformatf("w8_cout%0d", c), cout8, 1);
            chk($sformatf("w8_zero%0d", c), zero8, FL);
            chk($sformatf("w8_ovf%0d", c), ovf8, 0);
         end
         @(negedge clk);
      end
      in_valid8 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
